// File: rtl/dma_read_arbiter.sv
// Round-robin arbiter sharing one DMA read master among requesters.
// One read in flight: arbitrate, issue, wait (with watchdog), return.
module dma_read_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic [NUM_REQ-1:0]        i_REQ,
    input  logic [NUM_REQ*ADDR_W-1:0] i_REQ_ADDR,
    output logic [NUM_REQ-1:0]        o_GNT,
    output logic [NUM_REQ-1:0]        o_RVALID,
    output logic [DATA_W-1:0]         o_RDATA,
    output logic                      o_ERR,
    output logic                      o_BUSY,
    output logic                      o_MST_READ,
    output logic [ADDR_W-1:0]         o_MST_ADDR,
    input  logic                      i_MST_READY,
    input  logic                      i_MST_DONE,
    input  logic [DATA_W-1:0]         i_MST_RDATA,
    input  logic                      i_MST_ERR
);

    localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TMO_LAST =
        (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam logic [OW-1:0] LAST_INIT = OW'(NUM_REQ - 1);

    if (NUM_REQ < 2) begin : g_bad_num_req
        $error("dma_read_arbiter needs NUM_REQ >= 2");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RETURN
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [OW-1:0]      owner_q;
    logic [OW-1:0]      last_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [NUM_REQ-1:0] gnt_q;
    logic [CW-1:0]      cnt_q;
    logic [DATA_W-1:0]  rdata_q;
    logic               err_q;

    logic               pick_vld;
    logic [OW-1:0]      pick;
    logic [OW-1:0]      cand;
    logic [ADDR_W-1:0]  sel_addr;
    logic [NUM_REQ-1:0] pick_oh;
    logic [NUM_REQ-1:0] owner_oh;
    logic               tmo_hit;

    // Round-robin pick: first requester after the last one served.
    always_comb begin
        pick_vld = 1'b0;
        pick     = '0;
        cand     = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = OW'((int'(last_q) + i) % NUM_REQ);
            if (!pick_vld && i_REQ[cand]) begin
                pick_vld = 1'b1;
                pick     = cand;
            end
        end
    end

    // Address of the picked requester.
    always_comb begin
        sel_addr = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (OW'(k) == pick) begin
                sel_addr = i_REQ_ADDR[k*ADDR_W +: ADDR_W];
            end
        end
    end

    assign pick_oh  = NUM_REQ'(1) << pick;
    assign owner_oh = NUM_REQ'(1) << owner_q;

    // Watchdog fires on the last allowed WAIT cycle; disabled when 0.
    assign tmo_hit = (TIMEOUT != 0) && (cnt_q == TMO_LAST);

    // State register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a completed read beats the watchdog.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (i_MST_READY) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_MST_DONE || tmo_hit) begin
                    state_d = S_RETURN;
                end
            end
            S_RETURN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Transaction registers: owner, address, grant pulse, counter, result.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            owner_q <= '0;
            last_q  <= LAST_INIT;
            addr_q  <= '0;
            gnt_q   <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            gnt_q <= '0;
            unique case (state_q)
                S_IDLE: begin
                    if (pick_vld) begin
                        owner_q <= pick;
                        addr_q  <= sel_addr;
                        gnt_q   <= pick_oh;
                    end
                end
                S_ISSUE: begin
                    if (i_MST_READY) begin
                        cnt_q <= '0;
                    end
                end
                S_WAIT: begin
                    if (i_MST_DONE) begin
                        rdata_q <= i_MST_RDATA;
                        err_q   <= i_MST_ERR;
                    end else if (tmo_hit) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_RETURN: begin
                    last_q <= owner_q;
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decoded from state; address visible only while in flight.
    always_comb begin
        o_GNT      = gnt_q;
        o_RVALID   = '0;
        o_MST_READ = 1'b0;
        o_MST_ADDR = '0;
        o_BUSY     = (state_q != S_IDLE);
        unique case (state_q)
            S_ISSUE: begin
                o_MST_READ = 1'b1;
                o_MST_ADDR = addr_q;
            end
            S_WAIT: begin
                o_MST_ADDR = addr_q;
            end
            S_RETURN: begin
                o_RVALID = owner_oh;
            end
            default: begin
            end
        endcase
    end

    assign o_RDATA = rdata_q;
    assign o_ERR   = err_q;

endmodule
